msrv32_dmem_responder: RTL and testbench

AHB-lite-style data-memory responder (slave) on the far end of the core's store/load data-memory port.
- Accepts address phases (address, write request, byte-lane write mask, HTRANS) from the core.
- Inserts a configurable number of wait states.
- Commits masked writes or returns read words, and signals out-of-range accesses with a two-cycle error response.
- Holds the memory array internally. Used as data memory in simulation and FPGA builds.

---
 rtl/msrv32_dmem_pkg.sv | 20 ++
 rtl/msrv32_dmem_array.sv | 28 ++
 rtl/msrv32_dmem_responder.sv | 107 ++++++++++
 tb/tb_msrv32_dmem_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_dmem_pkg.sv
// Shared constants and state type for the data-memory responder.
// Encodes the HTRANS/HRESP values and the responder FSM states.
package msrv32_dmem_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} dmem_state_t;

   // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY never do.
   function automatic logic is_transfer(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/msrv32_dmem_array.sv
// Word-addressed storage for the responder: async read, byte-enabled sync write.
// Contents are deliberately not reset.
module msrv32_dmem_array #(
   parameter int MEM_WORDS = 1024,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [MEM_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/msrv32_dmem_responder.sv
// AHB-lite-style data-memory slave: wait-state insertion, masked writes,
// combinational read return and a two-cycle ERROR response for out-of-range addresses.
module msrv32_dmem_responder
   import msrv32_dmem_pkg::*;
#(
   parameter int          MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_n_in,
   input  logic [31:0] ms_riscv32_mp_dmaddr_in,
   input  logic [31:0] ms_riscv32_mp_dmdata_in,
   input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
   input  logic        ms_riscv32_mp_dmwr_req_in,
   input  logic [1:0]  ahb_htrans_in,
   output logic        ahb_ready_out,
   output logic        ahb_resp_out,
   output logic [31:0] ms_riscv32_mp_dmrd_data_out
);

   localparam int AW = $clog2(MEM_WORDS);

   dmem_state_t   state_q, state_d;
   logic [3:0]    wait_cnt_q, wait_cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          wr_q, wr_d;
   logic [3:0]    mask_q, mask_d;

   logic [32:0] offset;
   logic        range_err;
   logic        complete;
   logic        accept;
   logic        arr_we;
   logic [31:0] arr_rdata;
   logic        unused_addr_lsbs;

   // 33-bit offset: bit 32 set means the address lies below BASE_ADDR.
   assign offset           = {1'b0, ms_riscv32_mp_dmaddr_in} - {1'b0, BASE_ADDR};
   assign range_err        = offset[32] || ({2'b00, offset[31:2]} >= 32'(MEM_WORDS));
   assign unused_addr_lsbs = ^offset[1:0];

   assign complete      = (state_q == DATA) && (wait_cnt_q == 4'd0);
   assign ahb_ready_out = (state_q == IDLE) || (state_q == ERR2) || complete;
   assign ahb_resp_out  = ((state_q == ERR1) || (state_q == ERR2)) ? RESP_ERROR : RESP_OKAY;
   assign accept        = is_transfer(ahb_htrans_in) && ahb_ready_out;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      idx_d      = idx_q;
      wr_d       = wr_q;
      mask_d     = mask_q;
      if (state_q == ERR1) begin
         state_d = ERR2;
      end else if ((state_q == DATA) && !complete) begin
         wait_cnt_d = wait_cnt_q - 4'd1;
      end else if (accept) begin
         idx_d  = offset[AW+1:2];
         wr_d   = ms_riscv32_mp_dmwr_req_in;
         mask_d = ms_riscv32_mp_dmwr_mask_in;
         if (range_err) begin
            state_d = ERR1;
         end else begin
            state_d    = DATA;
            wait_cnt_d = 4'(WAIT_STATES);
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         state_q    <= IDLE;
         wait_cnt_q <= 4'd0;
         idx_q      <= '0;
         wr_q       <= 1'b0;
         mask_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         idx_q      <= idx_d;
         wr_q       <= wr_d;
         mask_q     <= mask_d;
      end
   end

   // Write data arrives in the data phase, so the commit happens on the completion edge.
   assign arr_we = complete && wr_q;

   msrv32_dmem_array #(
      .MEM_WORDS(MEM_WORDS),
      .AW       (AW)
   ) u_array (
      .clk_i  (ms_riscv32_mp_clk_in),
      .we_i   (arr_we),
      .be_i   (mask_q),
      .waddr_i(idx_q),
      .wdata_i(ms_riscv32_mp_dmdata_in),
      .raddr_i(idx_q),
      .rdata_o(arr_rdata)
   );

   assign ms_riscv32_mp_dmrd_data_out = (complete && !wr_q) ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Bench for msrv32_dmem_responder: three configurations checked cycle by cycle
// against a transaction-level memory model and a planned response timeline.
module tb_msrv32_dmem_responder;
   import msrv32_dmem_pkg::*;

   localparam int          NI         = 3;
   localparam int          WS    [NI] = '{0, 2, 0};
   localparam logic [31:0] BASE  [NI] = '{32'h0, 32'h0, 32'h1000};
   localparam int          WORDS [NI] = '{64, 64, 16};

   typedef struct {
      logic [1:0]  htrans;
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic        e_ready;
      logic        e_resp;
      logic [31:0] e_rdata;
   } cyc_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
      int          gap;
   } xfer_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr   [NI];
   logic [31:0] wdata  [NI];
   logic [3:0]  mask   [NI];
   logic        wr     [NI];
   logic [1:0]  htrans [NI];
   logic        ready  [NI];
   logic        resp   [NI];
   logic [31:0] rdata  [NI];

   logic [31:0] mem_m [NI][64];
   cyc_t        plan_q[$];
   xfer_t       xq[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   msrv32_dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_n_in     (rst_n),
      .ms_riscv32_mp_dmaddr_in    (addr[0]),
      .ms_riscv32_mp_dmdata_in    (wdata[0]),
      .ms_riscv32_mp_dmwr_mask_in (mask[0]),
      .ms_riscv32_mp_dmwr_req_in  (wr[0]),
      .ahb_htrans_in              (htrans[0]),
      .ahb_ready_out              (ready[0]),
      .ahb_resp_out               (resp[0]),
      .ms_riscv32_mp_dmrd_data_out(rdata[0])
   );

   msrv32_dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut1 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_n_in     (rst_n),
      .ms_riscv32_mp_dmaddr_in    (addr[1]),
      .ms_riscv32_mp_dmdata_in    (wdata[1]),
      .ms_riscv32_mp_dmwr_mask_in (mask[1]),
      .ms_riscv32_mp_dmwr_req_in  (wr[1]),
      .ahb_htrans_in              (htrans[1]),
      .ahb_ready_out              (ready[1]),
      .ahb_resp_out               (resp[1]),
      .ms_riscv32_mp_dmrd_data_out(rdata[1])
   );

   msrv32_dmem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h1000), .WAIT_STATES(0)) dut2 (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_n_in     (rst_n),
      .ms_riscv32_mp_dmaddr_in    (addr[2]),
      .ms_riscv32_mp_dmdata_in    (wdata[2]),
      .ms_riscv32_mp_dmwr_mask_in (mask[2]),
      .ms_riscv32_mp_dmwr_req_in  (wr[2]),
      .ahb_htrans_in              (htrans[2]),
      .ahb_ready_out              (ready[2]),
      .ahb_resp_out               (resp[2]),
      .ms_riscv32_mp_dmrd_data_out(rdata[2])
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_err(input int i, input logic [31:0] a);
      longint d;
      d = longint'({32'b0, a}) - longint'({32'b0, BASE[i]});
      return (d < 0) || ((d / 4) >= longint'(WORDS[i]));
   endfunction

   function automatic int m_idx(input int i, input logic [31:0] a);
      return int'((a - BASE[i]) >> 2);
   endfunction

   function automatic logic [31:0] rand_addr(input int i);
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return BASE[i] + 32'(4 * WORDS[i]) + 32'($urandom_range(0, 255));
      if (r == 1 && BASE[i] != 32'h0) return BASE[i] - 32'($urandom_range(1, 64));
      if (r == 1) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      return BASE[i] + 32'(4 * $urandom_range(0, WORDS[i] - 1)) + 32'($urandom_range(0, 3));
   endfunction

   task automatic add(input bit w, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d, input int gap);
      xfer_t x;
      x.wr = w; x.addr = a; x.mask = m; x.data = d; x.gap = gap;
      xq.push_back(x);
   endtask

   // Cycle with ignored/idle address inputs and the given expected outputs.
   task automatic push_cyc(input logic [1:0] ht, input logic [31:0] wd,
                           input logic er, input logic es, input logic [31:0] ed);
      cyc_t c;
      c.htrans = ht; c.addr = $urandom; c.wr = 1'($urandom); c.mask = 4'($urandom);
      c.wdata = wd; c.e_ready = er; c.e_resp = es; c.e_rdata = ed;
      plan_q.push_back(c);
   endtask

   // Turns the pending transfers into a per-cycle stimulus/expectation timeline,
   // offering each address phase as soon as the bus is expected to be ready.
   task automatic plan_xfers(input int i);
      logic        pr, ps;
      logic [31:0] pd, pw;
      xfer_t       x;
      cyc_t        c;
      int          k;
      pr = 1'b1; ps = 1'b0; pd = 32'd0; pw = $urandom;
      while (xq.size() > 0) begin
         x = xq.pop_front();
         for (int g = 0; g < x.gap; g++) begin
            push_cyc(2'($urandom_range(0, 1)), pw, pr, ps, pd);
            pr = 1'b1; ps = 1'b0; pd = 32'd0; pw = $urandom;
         end
         c.htrans = 2'($urandom_range(2, 3)); c.addr = x.addr; c.wr = x.wr; c.mask = x.mask;
         c.wdata = pw; c.e_ready = pr; c.e_resp = ps; c.e_rdata = pd;
         plan_q.push_back(c);
         if (m_err(i, x.addr)) begin
            push_cyc(2'($urandom), $urandom, 1'b0, 1'b1, 32'd0);
            pr = 1'b1; ps = 1'b1; pd = 32'd0; pw = $urandom;
         end else begin
            k = m_idx(i, x.addr);
            for (int w = 0; w < WS[i]; w++) push_cyc(2'($urandom), x.data, 1'b0, 1'b0, 32'd0);
            pr = 1'b1; ps = 1'b0; pw = x.data;
            pd = x.wr ? 32'd0 : mem_m[i][k];
            if (x.wr) begin
               for (int b = 0; b < 4; b++)
                  if (x.mask[b]) mem_m[i][k][8*b +: 8] = x.data[8*b +: 8];
            end
         end
      end
      push_cyc(HTRANS_IDLE, pw, pr, ps, pd);
      push_cyc(HTRANS_IDLE, $urandom, 1'b1, 1'b0, 32'd0);
   endtask

   // ---------------- driver ----------------
   task automatic run_plan(input int i, input string name);
      cyc_t c;
      int   k;
      k = 0;
      while (plan_q.size() > 0) begin
         c = plan_q.pop_front();
         @(posedge clk); #1;
         htrans[i] = c.htrans; addr[i] = c.addr; wr[i] = c.wr;
         mask[i] = c.mask; wdata[i] = c.wdata;
         @(negedge clk);
         check($sformatf("%s i%0d c%0d ready", name, i, k), 32'(ready[i]), 32'(c.e_ready));
         check($sformatf("%s i%0d c%0d resp", name, i, k), 32'(resp[i]), 32'(c.e_resp));
         check($sformatf("%s i%0d c%0d rdata", name, i, k), rdata[i], c.e_rdata);
         k++;
      end
   endtask

   task automatic do_plan(input int i, input string name);
      plan_xfers(i);
      run_plan(i, name);
   endtask

   // ---------------- sequence ----------------
   initial begin
      logic [31:0] old_v;
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         htrans[i] = HTRANS_IDLE; addr[i] = '0; wr[i] = 1'b0; mask[i] = '0; wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset i%0d ready", i), 32'(ready[i]), 32'd1);
         check($sformatf("reset i%0d resp", i), 32'(resp[i]), 32'd0);
         check($sformatf("reset i%0d rdata", i), rdata[i], 32'd0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < NI; i++) begin
         for (int w = 0; w < WORDS[i]; w++) add(1'b1, BASE[i] + 32'(4 * w), 4'hF, $urandom, 0);
         do_plan(i, "fill");
      end

      add(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
      add(1'b0, 32'h10, 4'h0, 32'h0, 0);
      do_plan(0, "wr_rd");
      add(1'b1, 32'h10, 4'b0100, 32'h00AB0000, 1);
      add(1'b0, 32'h10, 4'h0, 32'h0, 0);
      add(1'b1, 32'h12, 4'b1100, 32'h12340000, 0);
      add(1'b0, 32'h11, 4'h0, 32'h0, 0);
      add(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0);
      add(1'b0, 32'h10, 4'h0, 32'h0, 0);
      do_plan(0, "lanes");
      add(1'b1, 32'h0000_0100, 4'hF, 32'h5555AAAA, 0);
      add(1'b0, 32'h0000_0100, 4'h0, 32'h0, 0);
      add(1'b0, 32'h10, 4'h0, 32'h0, 2);
      add(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 0);
      add(1'b0, 32'h20, 4'h0, 32'h0, 0);
      do_plan(0, "err_pipe");

      add(1'b0, 32'h10, 4'h0, 32'h0, 0);
      add(1'b1, 32'h10, 4'hF, 32'h600DF00D, 0);
      add(1'b0, 32'h10, 4'h0, 32'h0, 0);
      add(1'b1, 32'h100, 4'hF, 32'h0, 0);
      add(1'b0, 32'h10, 4'h0, 32'h0, 0);
      do_plan(1, "waits");

      add(1'b1, 32'h0FFC, 4'hF, 32'h11111111, 0);
      add(1'b1, 32'h1040, 4'hF, 32'h22222222, 0);
      add(1'b0, 32'h1000, 4'h0, 32'h0, 0);
      add(1'b1, 32'h103C, 4'hF, 32'h33333333, 0);
      add(1'b0, 32'h103C, 4'h0, 32'h0, 0);
      do_plan(2, "base");

      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 40; n++)
            add(1'($urandom), rand_addr(i), 4'($urandom), $urandom, $urandom_range(0, 2));
         do_plan(i, "rand");
      end

      // Reset in the middle of a waited write must drop the write.
      old_v = mem_m[1][4];
      @(posedge clk); #1;
      htrans[1] = HTRANS_NONSEQ; addr[1] = 32'h10; wr[1] = 1'b1; mask[1] = 4'hF;
      wdata[1] = ~old_v;
      @(posedge clk); #1;
      htrans[1] = HTRANS_IDLE;
      @(negedge clk);
      check("rst_mid pre ready", 32'(ready[1]), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst_mid ready", 32'(ready[1]), 32'd1);
      check("rst_mid resp", 32'(resp[1]), 32'd0);
      check("rst_mid rdata", rdata[1], 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      add(1'b0, 32'h10, 4'h0, 32'h0, 0);
      do_plan(1, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
